// File: rtl/kv_dma_if.sv
// Bundle of the command, SRAM0, KV-cache and status signals of kv_dma_engine.
// master = engine side, slave = decoder/memory side.
interface kv_dma_if #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 16,
  parameter int N_LAYERS = 4,
  parameter int N_HEADS  = 4,
  parameter int MAX_SEQ  = 16,
  parameter int MAX_DIM  = 64
) ();
  localparam int LAYER_W = $clog2(N_LAYERS);
  localparam int HEAD_W  = $clog2(N_HEADS);
  localparam int TIME_W  = $clog2(MAX_SEQ);
  localparam int IDX_W   = $clog2(MAX_DIM);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic              cmd_is_v;
  logic [15:0]       cmd_layer;
  logic [15:0]       cmd_head;
  logic [15:0]       cmd_k;
  logic [15:0]       cmd_vlen;
  logic [ADDR_W-1:0] cmd_addr;

  logic              sram_rd_en;
  logic              sram_wr_en;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  logic               kv_rd_en;
  logic               kv_wr_en;
  logic               kv_is_v;
  logic [LAYER_W-1:0] kv_layer;
  logic [HEAD_W-1:0]  kv_head;
  logic [TIME_W-1:0]  kv_time;
  logic [IDX_W-1:0]   kv_idx;
  logic [DATA_W-1:0]  kv_wdata;
  logic [DATA_W-1:0]  kv_rdata;

  logic busy;
  logic done;
  logic err;

  modport master (
    input  cmd_valid, cmd_op, cmd_is_v, cmd_layer, cmd_head, cmd_k, cmd_vlen, cmd_addr,
    output cmd_ready,
    output sram_rd_en, sram_wr_en, sram_addr, sram_wdata,
    input  sram_rdata,
    output kv_rd_en, kv_wr_en, kv_is_v, kv_layer, kv_head, kv_time, kv_idx, kv_wdata,
    input  kv_rdata,
    output busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_is_v, cmd_layer, cmd_head, cmd_k, cmd_vlen, cmd_addr,
    input  cmd_ready,
    input  sram_rd_en, sram_wr_en, sram_addr, sram_wdata,
    output sram_rdata,
    input  kv_rd_en, kv_wr_en, kv_is_v, kv_layer, kv_head, kv_time, kv_idx, kv_wdata,
    output kv_rdata,
    input  busy, done, err
  );
endinterface

// File: rtl/kv_dma_engine.sv
// KV-cache DMA: APPEND copies one vector SRAM0 -> cache, READ copies k vectors cache -> SRAM0.
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// CHECK | validate captured fields
// RUN   | issue one read per cycle, write side trails by one
// DRAIN | final write only
// DONE  | one-cycle done/err pulse
module kv_dma_engine #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 16,
  parameter int N_LAYERS = 4,
  parameter int N_HEADS  = 4,
  parameter int MAX_SEQ  = 16,
  parameter int MAX_DIM  = 64
) (
  input logic      clk,
  input logic      rst,
  kv_dma_if.master bus
);
  localparam int LAYER_W = $clog2(N_LAYERS);
  localparam int HEAD_W  = $clog2(N_HEADS);
  localparam int TIME_W  = $clog2(MAX_SEQ);
  localparam int IDX_W   = $clog2(MAX_DIM);
  localparam logic [15:0] LAYER_LIM = 16'(N_LAYERS);
  localparam logic [15:0] HEAD_LIM  = 16'(N_HEADS);
  localparam logic [15:0] SEQ_LIM   = 16'(MAX_SEQ);
  localparam logic [15:0] DIM_LIM   = 16'(MAX_DIM);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state, state_nx;

  logic [3:0]        op_r;
  logic              is_v_r;
  logic [15:0]       layer_r, head_r, k_r, vlen_r;
  logic [ADDR_W-1:0] base_r;
  logic              err_r;
  logic [IDX_W-1:0]  cnt_i, vlen_m1, wr_idx;
  logic [TIME_W-1:0] cnt_t, t_end;
  logic [ADDR_W-1:0] row_off, wr_addr, rd_addr;
  logic              wr_pend;
  logic              is_read, bad, last_el, run;

  assign is_read = (op_r == 4'd9);
  assign run     = (state == S_RUN);
  assign last_el = (cnt_i == vlen_m1) && (cnt_t == t_end);
  // row_off accumulates vlen per row, so READ addressing needs no multiplier
  assign rd_addr = base_r + row_off + ADDR_W'(cnt_i);

  always_comb begin
    bad = 1'b0;
    if (op_r != 4'd8 && op_r != 4'd9)        bad = 1'b1;
    if (layer_r >= LAYER_LIM)                bad = 1'b1;
    if (head_r >= HEAD_LIM)                  bad = 1'b1;
    if (vlen_r == 16'd0 || vlen_r > DIM_LIM) bad = 1'b1;
    if (op_r == 4'd8 && k_r >= SEQ_LIM)      bad = 1'b1;
    if (op_r == 4'd9 && k_r > SEQ_LIM)       bad = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.cmd_valid) state_nx = S_CHECK;
      S_CHECK: begin
        if (bad || (is_read && k_r == 16'd0)) state_nx = S_DONE;
        else                                  state_nx = S_RUN;
      end
      S_RUN:   if (last_el) state_nx = S_DRAIN;
      S_DRAIN: state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_r    <= '0;
      is_v_r  <= 1'b0;
      layer_r <= '0;
      head_r  <= '0;
      k_r     <= '0;
      vlen_r  <= '0;
      base_r  <= '0;
      err_r   <= 1'b0;
      cnt_i   <= '0;
      cnt_t   <= '0;
      vlen_m1 <= '0;
      t_end   <= '0;
      row_off <= '0;
      wr_pend <= 1'b0;
      wr_addr <= '0;
      wr_idx  <= '0;
    end else begin
      wr_pend <= run;
      if (state == S_IDLE && bus.cmd_valid) begin
        op_r    <= bus.cmd_op;
        is_v_r  <= bus.cmd_is_v;
        layer_r <= bus.cmd_layer;
        head_r  <= bus.cmd_head;
        k_r     <= bus.cmd_k;
        vlen_r  <= bus.cmd_vlen;
        base_r  <= bus.cmd_addr;
        err_r   <= 1'b0;
      end
      if (state == S_CHECK) begin
        err_r   <= bad;
        cnt_i   <= '0;
        cnt_t   <= '0;
        row_off <= '0;
        vlen_m1 <= IDX_W'(vlen_r - 16'd1);
        t_end   <= is_read ? TIME_W'(k_r - 16'd1) : '0;
      end
      if (run) begin
        wr_addr <= rd_addr;
        wr_idx  <= cnt_i;
        if (cnt_i == vlen_m1) begin
          cnt_i   <= '0;
          cnt_t   <= cnt_t + TIME_W'(1);
          row_off <= row_off + ADDR_W'(vlen_r);
        end else begin
          cnt_i <= cnt_i + IDX_W'(1);
        end
      end
    end
  end

  assign bus.cmd_ready  = (state == S_IDLE);
  assign bus.busy       = (state != S_IDLE);
  assign bus.done       = (state == S_DONE);
  assign bus.err        = (state == S_DONE) && err_r;

  assign bus.sram_rd_en = run && !is_read;
  assign bus.kv_rd_en   = run && is_read;
  assign bus.kv_wr_en   = wr_pend && !is_read;
  assign bus.sram_wr_en = wr_pend && is_read;

  assign bus.sram_addr  = bus.sram_rd_en ? rd_addr : (bus.sram_wr_en ? wr_addr : '0);
  assign bus.sram_wdata = bus.sram_wr_en ? bus.kv_rdata : '0;
  assign bus.kv_wdata   = bus.kv_wr_en ? bus.sram_rdata : '0;
  assign bus.kv_time    = bus.kv_wr_en ? k_r[TIME_W-1:0] : (bus.kv_rd_en ? cnt_t : '0);
  assign bus.kv_idx     = bus.kv_wr_en ? wr_idx : (bus.kv_rd_en ? cnt_i : '0);
  assign bus.kv_is_v    = is_v_r;
  assign bus.kv_layer   = layer_r[LAYER_W-1:0];
  assign bus.kv_head    = head_r[HEAD_W-1:0];
endmodule

// File: tb/tb_kv_dma_engine.sv
// Bench for kv_dma_engine: memory models answer reads, a scoreboard queue checks every write.
module tb_kv_dma_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kv_dma_if bus ();
  kv_dma_engine dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit         to_sram;
    logic [15:0] addr;
    logic        is_v;
    logic [1:0]  layer;
    logic [1:0]  head;
    logic [3:0]  tm;
    logic [5:0]  idx;
    logic [7:0]  data;
  } exp_t;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] sram_m  [0:65535];
  logic [7:0] cache_m [0:32767];
  exp_t expq[$];
  exp_t e_mon;
  int tick = 0;
  int t0 = 0;
  int n_rd = 0, n_wr = 0, first_wr = -1, last_wr = -1;

  always @(posedge clk) tick <= tick + 1;

  always @(posedge clk) begin
    if (bus.sram_rd_en) bus.sram_rdata <= sram_m[bus.sram_addr];
    if (bus.kv_rd_en)
      bus.kv_rdata <= cache_m[{bus.kv_is_v, bus.kv_layer, bus.kv_head, bus.kv_time, bus.kv_idx}];
  end

  function automatic logic [39:0] pack_e(exp_t e);
    if (e.to_sram) return {1'b1, e.addr, 15'h0, e.data};
    return {1'b0, 16'h0, e.is_v, e.layer, e.head, e.tm, e.idx, e.data};
  endfunction

  // scoreboard: pop and compare one expected entry per observed write
  always @(negedge clk) begin
    logic [39:0] got;
    if (bus.sram_rd_en || bus.kv_rd_en) n_rd++;
    if (bus.sram_wr_en || bus.kv_wr_en) begin
      n_wr++;
      if (first_wr < 0) first_wr = tick;
      last_wr = tick;
      if (bus.sram_wr_en)
        got = {1'b1, bus.sram_addr, 15'h0, bus.sram_wdata};
      else
        got = {1'b0, 16'h0, bus.kv_is_v, bus.kv_layer, bus.kv_head, bus.kv_time, bus.kv_idx, bus.kv_wdata};
      vectors++;
      if (expq.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected_write tick=%0d got=%h", tick, got);
      end else begin
        e_mon = expq.pop_front();
        if (got !== pack_e(e_mon)) begin
          miscompares++;
          $display("FAIL sb_write tick=%0d got=%h exp=%h", tick, got, pack_e(e_mon));
        end
      end
    end
  end

  task automatic push_kv(input logic isv, input logic [1:0] l, input logic [1:0] h,
                         input logic [3:0] tm, input logic [5:0] i, input logic [7:0] d);
    exp_t e;
    e.to_sram = 1'b0; e.addr = '0; e.is_v = isv; e.layer = l; e.head = h;
    e.tm = tm; e.idx = i; e.data = d;
    expq.push_back(e);
  endtask

  task automatic push_sram(input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    e.to_sram = 1'b1; e.addr = a; e.is_v = 1'b0; e.layer = '0; e.head = '0;
    e.tm = '0; e.idx = '0; e.data = d;
    expq.push_back(e);
  endtask

  task automatic push_append(input logic isv, input int l, input int h, input int k,
                             input int vlen, input logic [15:0] src);
    for (int i = 0; i < vlen; i++)
      push_kv(isv, 2'(l), 2'(h), 4'(k), 6'(i), sram_m[16'(src + 16'(i))]);
  endtask

  task automatic push_read(input logic isv, input int l, input int h, input int k,
                           input int vlen, input logic [15:0] dst);
    logic [15:0] a;
    for (int t = 0; t < k; t++)
      for (int i = 0; i < vlen; i++) begin
        a = dst + 16'(t * vlen + i);
        push_sram(a, cache_m[{isv, 2'(l), 2'(h), 4'(t), 6'(i)}]);
      end
  endtask

  task automatic send(input logic [3:0] op, input logic isv, input logic [15:0] layer,
                      input logic [15:0] head, input logic [15:0] k, input logic [15:0] vlen,
                      input logic [15:0] addr);
    @(negedge clk);
    bus.cmd_op = op; bus.cmd_is_v = isv; bus.cmd_layer = layer; bus.cmd_head = head;
    bus.cmd_k = k; bus.cmd_vlen = vlen; bus.cmd_addr = addr; bus.cmd_valid = 1'b1;
    t0 = tick; n_rd = 0; n_wr = 0; first_wr = -1; last_wr = -1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic do_cmd(input logic [3:0] op, input logic isv, input logic [15:0] layer,
                        input logic [15:0] head, input logic [15:0] k, input logic [15:0] vlen,
                        input logic [15:0] addr, input int budget,
                        output int done_c, output logic err_o, output logic rdy_at_done,
                        output logic done_after, output logic rdy_after);
    send(op, isv, layer, head, k, vlen, addr);
    done_c = -1; err_o = 1'bx; rdy_at_done = 1'bx;
    for (int c = 1; c <= budget; c++) begin
      if (bus.done) begin
        done_c = tick - t0; err_o = bus.err; rdy_at_done = bus.cmd_ready;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    done_after = bus.done; rdy_after = bus.cmd_ready;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.cmd_ready, bus.busy, bus.done, bus.err} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_status got=%b exp=1000", {bus.cmd_ready, bus.busy, bus.done, bus.err});
    end
    vectors++;
    if ({bus.sram_rd_en, bus.sram_wr_en, bus.kv_rd_en, bus.kv_wr_en} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_strobes got=%b exp=0000",
               {bus.sram_rd_en, bus.sram_wr_en, bus.kv_rd_en, bus.kv_wr_en});
    end
    vectors++;
    if ({bus.sram_addr, bus.sram_wdata, bus.kv_wdata, bus.kv_time, bus.kv_idx} !== '0) begin
      miscompares++;
      $display("FAIL reset_data got=%h/%h/%h/%h/%h exp=0", bus.sram_addr, bus.sram_wdata,
               bus.kv_wdata, bus.kv_time, bus.kv_idx);
    end
    rst = 1'b0;
  endtask

  task automatic test_append;
    int dc; logic er, rd0, da, ra;
    for (int i = 0; i < 4; i++) sram_m[16'h0100 + 16'(i)] = 8'h11 + 8'(i);
    push_append(1'b0, 1, 2, 5, 4, 16'h0100);
    do_cmd(4'd8, 1'b0, 16'd1, 16'd2, 16'd5, 16'd4, 16'h0100, 50, dc, er, rd0, da, ra);
    vectors++; if (dc !== 7) begin miscompares++; $display("FAIL append_done_cycle got=%0d exp=7", dc); end
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL append_err got=%b exp=0", er); end
    vectors++; if (first_wr - t0 !== 3 || last_wr - t0 !== 6) begin
      miscompares++; $display("FAIL append_write_window got=%0d..%0d exp=3..6", first_wr - t0, last_wr - t0); end
    vectors++; if (n_rd !== 4 || n_wr !== 4) begin
      miscompares++; $display("FAIL append_counts got=rd%0d wr%0d exp=rd4 wr4", n_rd, n_wr); end
    vectors++; if ({rd0, da, ra} !== 3'b001) begin
      miscompares++; $display("FAIL append_done_ready got=%b exp=001", {rd0, da, ra}); end
    vectors++; if (expq.size() !== 0) begin
      miscompares++; $display("FAIL append_missing got=%0d left exp=0", expq.size()); end
  endtask

  task automatic test_read;
    int dc; logic er, rd0, da, ra;
    push_read(1'b1, 0, 3, 3, 2, 16'h0200);
    do_cmd(4'd9, 1'b1, 16'd0, 16'd3, 16'd3, 16'd2, 16'h0200, 50, dc, er, rd0, da, ra);
    vectors++; if (dc !== 9) begin miscompares++; $display("FAIL read_done_cycle got=%0d exp=9", dc); end
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL read_err got=%b exp=0", er); end
    vectors++; if (n_wr !== 6 || first_wr - t0 !== 3 || last_wr - t0 !== 8) begin
      miscompares++; $display("FAIL read_writes got=%0d @%0d..%0d exp=6 @3..8", n_wr, first_wr - t0, last_wr - t0); end
    vectors++; if (expq.size() !== 0) begin
      miscompares++; $display("FAIL read_missing got=%0d left exp=0", expq.size()); end
  endtask

  task automatic test_errors;
    logic [3:0]  ops [4] = '{4'd8, 4'd9, 4'd8, 4'd7};
    logic [15:0] lay [4] = '{16'd4, 16'd1, 16'd1, 16'd1};
    logic [15:0] kk  [4] = '{16'd2, 16'd2, 16'd16, 16'd2};
    logic [15:0] vl  [4] = '{16'd4, 16'd65, 16'd4, 16'd4};
    int dc; logic er, rd0, da, ra;
    for (int c = 0; c < 4; c++) begin
      do_cmd(ops[c], 1'b0, lay[c], 16'd1, kk[c], vl[c], 16'h0040, 20, dc, er, rd0, da, ra);
      vectors++;
      if (dc !== 2 || er !== 1'b1 || n_rd !== 0 || n_wr !== 0) begin
        miscompares++;
        $display("FAIL error_case%0d got=done@%0d err=%b rd=%0d wr=%0d exp=done@2 err=1 rd=0 wr=0",
                 c, dc, er, n_rd, n_wr);
      end
    end
  endtask

  task automatic test_read_zero;
    int dc; logic er, rd0, da, ra;
    do_cmd(4'd9, 1'b0, 16'd1, 16'd1, 16'd0, 16'd4, 16'h0080, 20, dc, er, rd0, da, ra);
    vectors++;
    if (dc !== 2 || er !== 1'b0 || n_rd !== 0 || n_wr !== 0) begin
      miscompares++;
      $display("FAIL read_k0 got=done@%0d err=%b rd=%0d wr=%0d exp=done@2 err=0 rd=0 wr=0", dc, er, n_rd, n_wr);
    end
  endtask

  task automatic test_read_full;
    int dc; logic er, rd0, da, ra;
    push_read(1'b0, 3, 1, 16, 64, 16'h1000);
    do_cmd(4'd9, 1'b0, 16'd3, 16'd1, 16'd16, 16'd64, 16'h1000, 1200, dc, er, rd0, da, ra);
    vectors++; if (dc !== 1027 || er !== 1'b0) begin
      miscompares++; $display("FAIL read_full_done got=%0d err=%b exp=1027 err=0", dc, er); end
    vectors++; if (n_wr !== 1024 || expq.size() !== 0) begin
      miscompares++; $display("FAIL read_full_count got=%0d left=%0d exp=1024 left=0", n_wr, expq.size()); end
  endtask

  task automatic test_wrap;
    int dc; logic er, rd0, da, ra;
    push_read(1'b1, 2, 0, 1, 4, 16'hFFFE);
    do_cmd(4'd9, 1'b1, 16'd2, 16'd0, 16'd1, 16'd4, 16'hFFFE, 50, dc, er, rd0, da, ra);
    vectors++; if (dc !== 7 || n_wr !== 4 || expq.size() !== 0) begin
      miscompares++; $display("FAIL wrap got=done@%0d wr=%0d left=%0d exp=done@7 wr=4 left=0", dc, n_wr, expq.size()); end
  endtask

  task automatic test_reset_mid;
    int dc; logic er, rd0, da, ra;
    push_append(1'b0, 0, 0, 3, 64, 16'h0300);
    send(4'd8, 1'b0, 16'd0, 16'd0, 16'd3, 16'd64, 16'h0300);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.sram_rd_en, bus.sram_wr_en, bus.kv_rd_en, bus.kv_wr_en} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_mid_strobes got=%b exp=0000",
               {bus.sram_rd_en, bus.sram_wr_en, bus.kv_rd_en, bus.kv_wr_en});
    end
    vectors++;
    if ({bus.cmd_ready, bus.busy} !== 2'b10) begin
      miscompares++; $display("FAIL reset_mid_status got=%b exp=10", {bus.cmd_ready, bus.busy});
    end
    rst = 1'b0;
    expq.delete();
    push_append(1'b1, 3, 3, 7, 3, 16'h0400);
    do_cmd(4'd8, 1'b1, 16'd3, 16'd3, 16'd7, 16'd3, 16'h0400, 50, dc, er, rd0, da, ra);
    vectors++; if (dc !== 6 || er !== 1'b0 || expq.size() !== 0) begin
      miscompares++; $display("FAIL after_reset got=done@%0d err=%b left=%0d exp=done@6 err=0 left=0", dc, er, expq.size()); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_is_v = 1'b0; bus.cmd_layer = '0;
    bus.cmd_head = '0; bus.cmd_k = '0; bus.cmd_vlen = '0; bus.cmd_addr = '0;
    for (int a = 0; a < 65536; a++) sram_m[a] = 8'(a * 13 + 7);
    for (int j = 0; j < 32768; j++) cache_m[j] = 8'((j * 29) ^ (j >> 5));
    test_reset;
    test_append;
    test_read;
    test_errors;
    test_read_zero;
    test_read_full;
    test_wrap;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
